mixer_if_meter: RTL and testbench

- Synthesizable, multi-channel successor to the behavioural mixer frequency model.
- Counts rising edges of N_CH RF inputs and one shared LO (osc) input over a programmable gate window of clk cycles.
- Per window, reports the signed edge-count difference (RF − LO) per channel, i.e. the intermediate frequency in counts/window.
- Sits between the RF front-end digital taps and the baseband/AGC logic; replaces the testbench-only period averaging.

---
 rtl/mixer_if_meter.sv | 215 +++++++++++++++++++++
 tb/tb_mixer_if_meter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mixer_if_meter.sv
// Multi-channel IF meter: counts RF and shared LO rising edges over a gate window of clk cycles
// and reports the signed per-channel difference. MIXER_IF_METER_AVG_EN enables group averaging.
module mixer_if_meter #(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WIN_W    = 16,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pd,
  input  logic                   en,
  input  logic                   start,
  input  logic [WIN_W-1:0]       win_len,
  input  logic [N_CH-1:0]        rf_in,
  input  logic                   osc_in,
  output logic [N_CH*CNT_W-1:0]  if_cnt,
  output logic [N_CH-1:0]        if_neg,
  output logic [N_CH-1:0]        ovf,
  output logic                   if_valid,
  output logic                   busy
);

  // Index N_CH of every input-path vector is the LO; lower indices are RF channels.
  localparam int unsigned NI = N_CH + 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [0:0] {StIdle, StMeasure} state_e;

  state_e           state_q, state_d;
  logic             cont_q, cont_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [WIN_W-1:0] len_q, len_d;
  logic             terminal, abort, clear, count;

  logic [NI-1:0]    s1_q, s2_q, s3_q, edge_q;
  logic [CNT_W-1:0] cnt_q [NI];
  logic [CNT_W-1:0] snap  [NI];
  logic [CNT_W:0]   diff  [N_CH];
  logic [N_CH-1:0]  ovf_now;

  logic             res_fire;
  logic [CNT_W:0]   res_val [N_CH];
  logic [CNT_W-1:0] res_mag [N_CH];
  logic [N_CH-1:0]  res_ovf;

  logic [N_CH*CNT_W-1:0] if_cnt_q;
  logic [N_CH-1:0]       if_neg_q, ovf_q;
  logic                  if_valid_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic e);
    return (c == CntMax) ? c : c + CNT_W'(e);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || pd) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      edge_q <= '0;
    end else begin
      s1_q   <= {osc_in, rf_in};
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      edge_q <= s2_q & ~s3_q;
    end
  end

  assign terminal = (state_q == StMeasure) && (win_cnt_q == len_q - WIN_W'(1));
  assign abort    = (state_q == StMeasure) && !terminal && cont_q && !en;

  always_comb begin
    state_d   = state_q;
    cont_d    = cont_q;
    win_cnt_d = win_cnt_q;
    len_d     = len_q;
    clear     = 1'b0;
    count     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en || start) begin
          state_d   = StMeasure;
          cont_d    = en;
          len_d     = (win_len == '0) ? WIN_W'(1) : win_len;
          win_cnt_d = '0;
          clear     = 1'b1;
        end
      end
      StMeasure: begin
        if (terminal) begin
          win_cnt_d = '0;
          clear     = 1'b1;
          cont_d    = en;
          if (!en) state_d = StIdle;
        end else if (abort) begin
          state_d = StIdle;
        end else begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
          count     = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || pd) begin
      state_q   <= StIdle;
      cont_q    <= 1'b0;
      win_cnt_q <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      cont_q    <= cont_d;
      win_cnt_q <= win_cnt_d;
      len_q     <= len_d;
    end
  end

  // The snapshot folds in the current strobe so terminal-cycle edges land in the ending window.
  always_comb begin
    for (int i = 0; i < NI; i++) snap[i] = sat_inc(cnt_q[i], edge_q[i]);
    for (int i = 0; i < N_CH; i++) begin
      diff[i]    = {1'b0, snap[i]} - {1'b0, snap[N_CH]};
      ovf_now[i] = (snap[i] == CntMax) || (snap[N_CH] == CntMax);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || pd) begin
      for (int i = 0; i < NI; i++) cnt_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NI; i++) cnt_q[i] <= '0;
    end else if (count) begin
      for (int i = 0; i < NI; i++) cnt_q[i] <= snap[i];
    end
  end

`ifdef MIXER_IF_METER_AVG_EN
  localparam int unsigned AccW = CNT_W + AVG_LOG2 + 1;

  logic signed [AccW-1:0] acc_q   [N_CH];
  logic signed [AccW-1:0] acc_sum [N_CH];
  logic [AVG_LOG2-1:0]    grp_q;
  logic [N_CH-1:0]        ovf_acc_q;

  // Only bits below the sign-fill region are kept, so the shift floors toward -inf.
  always_comb begin
    res_fire = terminal && (&grp_q);
    res_ovf  = ovf_now | ovf_acc_q;
    for (int i = 0; i < N_CH; i++) begin
      acc_sum[i] = acc_q[i] + {{AVG_LOG2{diff[i][CNT_W]}}, diff[i]};
      res_val[i] = (CNT_W+1)'(acc_sum[i] >>> AVG_LOG2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || pd || abort) begin
      grp_q     <= '0;
      ovf_acc_q <= '0;
      for (int i = 0; i < N_CH; i++) acc_q[i] <= '0;
    end else if (terminal) begin
      if (&grp_q) begin
        grp_q     <= '0;
        ovf_acc_q <= '0;
        for (int i = 0; i < N_CH; i++) acc_q[i] <= '0;
      end else begin
        grp_q     <= grp_q + AVG_LOG2'(1);
        ovf_acc_q <= ovf_acc_q | ovf_now;
        for (int i = 0; i < N_CH; i++) acc_q[i] <= acc_sum[i];
      end
    end
  end
`else
  logic unused_avg_cfg;
  assign unused_avg_cfg = ^AVG_LOG2;

  always_comb begin
    res_fire = terminal;
    res_ovf  = ovf_now;
    for (int i = 0; i < N_CH; i++) res_val[i] = diff[i];
  end
`endif

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      res_mag[i] = res_val[i][CNT_W] ? CNT_W'(-res_val[i]) : res_val[i][CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || pd) begin
      if_valid_q <= 1'b0;
      if_cnt_q   <= '0;
      if_neg_q   <= '0;
      ovf_q      <= '0;
    end else begin
      if_valid_q <= res_fire;
      if (res_fire) begin
        for (int i = 0; i < N_CH; i++) begin
          if_cnt_q[i*CNT_W +: CNT_W] <= res_mag[i];
          if_neg_q[i]                <= res_val[i][CNT_W];
        end
        ovf_q <= res_ovf;
      end
    end
  end

  assign if_cnt   = if_cnt_q;
  assign if_neg   = if_neg_q;
  assign ovf      = ovf_q;
  assign if_valid = if_valid_q;
  assign busy     = (state_q == StMeasure);

endmodule

// File: tb/tb_mixer_if_meter.sv
// Directed bench for mixer_if_meter: default-width instance plus a CNT_W=4 instance for saturation.
module tb_mixer_if_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, pd, en, start, en_s, start_s;
  logic [15:0] win_len, win_len_s;
  logic        gen_on;
  logic [1:0]  man_rf, gen_rf;
  logic        man_osc, gen_osc;
  wire  [1:0]  rf_in;
  wire         osc_in;

  logic [31:0] if_cnt;
  logic [1:0]  if_neg, ovf;
  logic        if_valid, busy;
  logic [7:0]  if_cnt_s;
  logic [1:0]  if_neg_s, ovf_s;
  logic        if_valid_s, busy_s;

  int unsigned ph = 0;
  int unsigned per0 = 0, per1 = 0, pero = 0;
  int          n_tests = 0, n_fail = 0;

  assign rf_in  = gen_on ? gen_rf : man_rf;
  assign osc_in = gen_on ? gen_osc : man_osc;

  mixer_if_meter dut (
    .clk(clk), .rst(rst), .pd(pd), .en(en), .start(start), .win_len(win_len),
    .rf_in(rf_in), .osc_in(osc_in), .if_cnt(if_cnt), .if_neg(if_neg), .ovf(ovf),
    .if_valid(if_valid), .busy(busy)
  );

  mixer_if_meter #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .pd(pd), .en(en_s), .start(start_s), .win_len(win_len_s),
    .rf_in(rf_in), .osc_in(osc_in), .if_cnt(if_cnt_s), .if_neg(if_neg_s), .ovf(ovf_s),
    .if_valid(if_valid_s), .busy(busy_s)
  );

  function automatic logic wave(input int unsigned t, input int unsigned p);
    return (p != 0) && ((t % p) < (p / 2));
  endfunction

  always @(negedge clk) begin
    ph      <= ph + 1;
    gen_rf  <= {wave(ph, per1), wave(ph, per0)};
    gen_osc <= wave(ph, pero);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input bit sat, input int limit, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!(sat ? if_valid_s : if_valid) && cyc < limit);
  endtask

  int cyc, sum_v, sum_c0, sum_c1;

  initial begin
    rst = 1'b1; pd = 1'b0; en = 1'b0; start = 1'b0; en_s = 1'b0; start_s = 1'b0;
    win_len = 16'd100; win_len_s = 16'd64;
    gen_on = 1'b1; man_rf = 2'b00; man_osc = 1'b0;
    steps(3);
    check("reset_valid", {31'd0, if_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_cnt", if_cnt, 32'd0);
    check("reset_neg", {30'd0, if_neg}, 32'd0);
    check("reset_ovf", {30'd0, ovf}, 32'd0);
    rst = 1'b0;

    // Continuous: 25 RF0 edges, 20 RF1 edges, 20 LO edges per 100-cycle window
    per0 = 4; per1 = 5; pero = 5;
    steps(10);
    win_len = 16'd100; en = 1'b1;
    wait_valid(1'b0, 300, cyc);
    check("cont_first_valid", {31'd0, if_valid}, 32'd1);
    for (int w = 0; w < 2; w++) begin
      wait_valid(1'b0, 150, cyc);
      check("cont_gap", cyc, 32'd100);
      check("cont_cnt0", if_cnt[15:0], 32'd5);
      check("cont_neg0", {31'd0, if_neg[0]}, 32'd0);
      check("cont_cnt1", if_cnt[31:16], 32'd0);
      check("cont_neg1", {31'd0, if_neg[1]}, 32'd0);
    end

    // Reset mid-window
    steps(30);
    rst = 1'b1; en = 1'b0;
    steps(2);
    rst = 1'b0;
    step();
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_valid", {31'd0, if_valid}, 32'd0);
    check("rst_mid_cnt", if_cnt, 32'd0);

    // One-shot negative IF: 20 RF0 edges vs 50 LO edges
    per0 = 10; per1 = 4; pero = 4;
    steps(10);
    win_len = 16'd200; start = 1'b1;
    step();
    start = 1'b0;
    check("oneshot_busy", {31'd0, busy}, 32'd1);
    wait_valid(1'b0, 400, cyc);
    check("oneshot_latency", cyc + 1, 32'd201);
    check("oneshot_cnt0", if_cnt[15:0], 32'd30);
    check("oneshot_neg0", {31'd0, if_neg[0]}, 32'd1);
    check("oneshot_cnt1", if_cnt[31:16], 32'd0);
    check("oneshot_neg1", {31'd0, if_neg[1]}, 32'd0);
    check("oneshot_busy_after", {31'd0, busy}, 32'd0);
    sum_v = 0;
    for (int i = 0; i < 250; i++) begin
      step();
      sum_v += int'(if_valid);
    end
    check("oneshot_single", sum_v, 32'd0);

    // win_len = 0: one-cycle windows, valid every cycle
    per0 = 4; per1 = 0; pero = 0;
    steps(10);
    win_len = 16'd0; en = 1'b1;
    steps(2);
    sum_v = 0; sum_c0 = 0; sum_c1 = 0;
    for (int i = 0; i < 8; i++) begin
      sum_v  += int'(if_valid);
      sum_c0 += int'(if_cnt[15:0]);
      sum_c1 += int'(if_cnt[31:16]);
      step();
    end
    check("win0_valid_every", sum_v, 32'd8);
    check("win0_sum_cnt0", sum_c0, 32'd2);
    check("win0_sum_cnt1", sum_c1, 32'd0);
    en = 1'b0;
    steps(2);
    check("win0_idle", {31'd0, busy}, 32'd0);

    // Single edge whose strobe lands on the terminal cycle of a 4-cycle window
    gen_on = 1'b0; man_rf = 2'b00; man_osc = 1'b0;
    steps(6);
    win_len = 16'd4; en = 1'b1;
    step();
    man_rf[0] = 1'b1;
    steps(4);
    check("term_valid1", {31'd0, if_valid}, 32'd1);
    check("term_cnt_win1", if_cnt[15:0], 32'd1);
    steps(4);
    check("term_valid2", {31'd0, if_valid}, 32'd1);
    check("term_cnt_win2", if_cnt[15:0], 32'd0);
    en = 1'b0;
    steps(2);
    check("term_idle", {31'd0, busy}, 32'd0);

    // Saturation on the 4-bit instance
    gen_on = 1'b1; per0 = 2; per1 = 0; pero = 0;
    steps(10);
    win_len_s = 16'd64; en_s = 1'b1;
    wait_valid(1'b1, 200, cyc);
    check("sat_valid", {31'd0, if_valid_s}, 32'd1);
    check("sat_ovf0", {31'd0, ovf_s[0]}, 32'd1);
    check("sat_ovf1", {31'd0, ovf_s[1]}, 32'd0);
    check("sat_cnt0", if_cnt_s[3:0], 32'd15);
    win_len_s = 16'd16; en_s = 1'b0;
    step();
    en_s = 1'b1;
    wait_valid(1'b1, 100, cyc);
    check("sat16_latency", cyc, 32'd17);
    check("sat16_ovf0", {31'd0, ovf_s[0]}, 32'd0);
    check("sat16_cnt0", if_cnt_s[3:0], 32'd8);
    en_s = 1'b0;

    // Power-down mid-window, with priority over en
    per0 = 4; per1 = 5; pero = 5;
    steps(10);
    win_len = 16'd100; en = 1'b1;
    wait_valid(1'b0, 150, cyc);
    check("pd_pre_cnt0", if_cnt[15:0], 32'd5);
    steps(20);
    pd = 1'b1;
    step();
    check("pd_busy", {31'd0, busy}, 32'd0);
    check("pd_cnt", if_cnt, 32'd0);
    check("pd_valid", {31'd0, if_valid}, 32'd0);
    steps(3);
    check("pd_hold_busy", {31'd0, busy}, 32'd0);
    pd = 1'b0;
    step();
    check("pd_release_busy", {31'd0, busy}, 32'd1);
    steps(10);
    en = 1'b0;
    steps(2);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_no_valid", {31'd0, if_valid}, 32'd0);
    check("abort_cnt_hold", if_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
